// File: rtl/led_share_arb.sv
// led_share_arb: round-robin arbiter sharing one 8-bit LED register between
// two valid/ready requesters. Each accepted write optionally blocks further
// writes for HOLD_CYCLES cycles.
// Optional feature: define LED_SHARE_ARB_BLINK_EN to rotate the LED pattern
// left by one after IDLE_TIMEOUT cycles without a transfer.
//
// state | meaning
// IDLE  | ready offered to the arbitration winner, transfer on valid & ready
// HOLD  | LED value held, both readies low, counter runs down to 0
module led_share_arb #(
    parameter int          HOLD_CYCLES  = 16,
    parameter logic [31:0] IDLE_TIMEOUT = 32'd50000000
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic       req_a_valid,
    input  logic [7:0] req_a_data,
    output logic       req_a_ready,
    input  logic       req_b_valid,
    input  logic [7:0] req_b_data,
    output logic       req_b_ready,
    output logic [7:0] led_wire_export,
    output logic [1:0] owner
);

    localparam int CW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [CW-1:0] HOLD_LOAD = (HOLD_CYCLES > 0) ? CW'(HOLD_CYCLES - 1) : CW'(0);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t        state;
    logic [CW-1:0] hold_cnt;
    logic          last_b;     // last grant went to B; resets to B so A wins the first tie
    logic          xfer;
    logic          rotate;

    // Arbitration: ready to at most one requester, only in IDLE and out of reset
    always_comb begin
        req_a_ready = 1'b0;
        req_b_ready = 1'b0;
        if (!reset_reset && state == IDLE) begin
            if (req_a_valid && (!req_b_valid || last_b))
                req_a_ready = 1'b1;
            else if (req_b_valid)
                req_b_ready = 1'b1;
        end
    end

    assign xfer = req_a_ready | req_b_ready;

`ifdef LED_SHARE_ARB_BLINK_EN
    localparam logic [31:0] TIMEOUT_LAST = IDLE_TIMEOUT - 32'd1;

    logic [31:0] idle_cnt;

    // Idle counter: cleared by a transfer or on reaching the timeout
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset)
            idle_cnt <= 32'd0;
        else if (xfer || idle_cnt == TIMEOUT_LAST)
            idle_cnt <= 32'd0;
        else
            idle_cnt <= idle_cnt + 32'd1;
    end

    // A transfer in the timeout cycle wins over the rotate
    assign rotate = !xfer && (idle_cnt == TIMEOUT_LAST);
`else
    logic [31:0] unused_idle_timeout;

    assign unused_idle_timeout = IDLE_TIMEOUT;
    assign rotate              = 1'b0;
`endif

    // FSM with registered LED, owner and round-robin pointer
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state           <= IDLE;
            hold_cnt        <= '0;
            last_b          <= 1'b1;
            led_wire_export <= 8'h00;
            owner           <= 2'b00;
        end else begin
            if (rotate)
                led_wire_export <= {led_wire_export[6:0], led_wire_export[7]};
            case (state)
                IDLE: begin
                    if (xfer) begin
                        led_wire_export <= req_a_ready ? req_a_data : req_b_data;
                        owner           <= req_a_ready ? 2'b01 : 2'b10;
                        last_b          <= req_b_ready;
                        if (HOLD_CYCLES > 0) begin
                            state    <= HOLD;
                            hold_cnt <= HOLD_LOAD;
                        end
                    end
                end
                HOLD: begin
                    if (hold_cnt == '0)
                        state <= IDLE;
                    else
                        hold_cnt <= hold_cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_share_arb.sv
// Testbench for led_share_arb: three instances (HOLD_CYCLES 4, 0, 16) share
// one stimulus stream and are checked every cycle against a timestamp-based
// reference model, plus directed scenarios with literal expectations.
module tb_led_share_arb;

    localparam int NI = 3;
    localparam int HC[NI] = '{4, 0, 16};
    localparam int T = 8;
`ifdef LED_SHARE_ARB_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       a_v, b_v;
    logic [7:0] a_d, b_d;
    logic       ra[NI];
    logic       rb[NI];
    logic [7:0] led[NI];
    logic [1:0] own[NI];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    led_share_arb #(.HOLD_CYCLES(4), .IDLE_TIMEOUT(T)) u_h4 (
        .clk_clk(clk), .reset_reset(rst),
        .req_a_valid(a_v), .req_a_data(a_d), .req_a_ready(ra[0]),
        .req_b_valid(b_v), .req_b_data(b_d), .req_b_ready(rb[0]),
        .led_wire_export(led[0]), .owner(own[0]));

    led_share_arb #(.HOLD_CYCLES(0), .IDLE_TIMEOUT(T)) u_h0 (
        .clk_clk(clk), .reset_reset(rst),
        .req_a_valid(a_v), .req_a_data(a_d), .req_a_ready(ra[1]),
        .req_b_valid(b_v), .req_b_data(b_d), .req_b_ready(rb[1]),
        .led_wire_export(led[1]), .owner(own[1]));

    led_share_arb #(.HOLD_CYCLES(16), .IDLE_TIMEOUT(T)) u_h16 (
        .clk_clk(clk), .reset_reset(rst),
        .req_a_valid(a_v), .req_a_data(a_d), .req_a_ready(ra[2]),
        .req_b_valid(b_v), .req_b_data(b_d), .req_b_ready(rb[2]),
        .led_wire_export(led[2]), .owner(own[2]));

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: acceptance allowed from edge m_next_ok on; rotations
    // happen T edges after the last transfer/rotation/reset.
    int         n = 0;
    int         m_next_ok[NI];
    int         m_last_ref[NI];
    int         m_last_grant[NI];   // 1 = A, 2 = B
    logic [7:0] m_led[NI];
    logic [1:0] m_own[NI];

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            int w;
            if (rst) begin
                m_next_ok[i]    = n;
                m_last_ref[i]   = n;
                m_last_grant[i] = 2;
                m_led[i]        = 8'h00;
                m_own[i]        = 2'b00;
            end
            w = 0;
            if (!rst && n >= m_next_ok[i]) begin
                if (a_v && b_v) w = 3 - m_last_grant[i];
                else if (a_v)   w = 1;
                else if (b_v)   w = 2;
            end
            chk($sformatf("model_ready_a[%0d]", i), ra[i], w == 1);
            chk($sformatf("model_ready_b[%0d]", i), rb[i], w == 2);
            chk($sformatf("model_led[%0d]", i), led[i], m_led[i]);
            chk($sformatf("model_owner[%0d]", i), own[i], m_own[i]);
            if (!rst) begin
                if (w != 0) begin
                    m_led[i]        = (w == 1) ? a_d : b_d;
                    m_own[i]        = w[1:0];
                    m_last_grant[i] = w;
                    m_next_ok[i]    = n + HC[i] + 1;
                    m_last_ref[i]   = n;
                end else if (BLINK && (n - m_last_ref[i]) == T) begin
                    m_led[i]      = {m_led[i][6:0], m_led[i][7]};
                    m_last_ref[i] = n;
                end
            end
        end
        n++;
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        next_cyc();
        rst = 1'b1; a_v = 1'b0; b_v = 1'b0;
        next_cyc();
        next_cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; a_v = 1'b1; a_d = 8'h5A; b_v = 1'b1; b_d = 8'h66;
        smp();
        smp();
        for (int i = 0; i < NI; i++) begin
            chk("reset_led", led[i], 8'h00);
            chk("reset_owner", {6'b0, own[i]}, 8'h00);
            chk("reset_ready", {6'b0, ra[i], rb[i]}, 8'h00);
        end

        // Single requester, HOLD_CYCLES=4
        next_cyc();
        rst = 1'b0; a_v = 1'b1; a_d = 8'hA5; b_v = 1'b0;
        smp();
        chk("h4_ready_a_c0", ra[0], 1'b1);
        for (int c = 1; c <= 4; c++) begin
            next_cyc();
            smp();
            chk("h4_led_hold", led[0], 8'hA5);
            chk("h4_owner_hold", {6'b0, own[0]}, 8'h01);
            chk("h4_ready_hold", {6'b0, ra[0], rb[0]}, 8'h00);
        end
        next_cyc();
        smp();
        chk("h4_ready_a_c5", ra[0], 1'b1);

        // Round-robin with no hold
        do_reset();
        a_v = 1'b1; a_d = 8'h11; b_v = 1'b1; b_d = 8'h22;
        for (int c = 0; c <= 4; c++) begin
            smp();
            if (c < 4) begin
                chk("rr_ready_a", ra[1], (c % 2) == 0);
                chk("rr_ready_b", rb[1], (c % 2) == 1);
            end
            if (c > 0)
                chk("rr_led", led[1], ((c - 1) % 2 == 0) ? 8'h11 : 8'h22);
            next_cyc();
        end

        // B raised during HOLD is served on the first IDLE cycle
        do_reset();
        a_v = 1'b1; a_d = 8'h5A; b_v = 1'b0;
        smp();
        next_cyc();
        a_v = 1'b0;
        smp();
        next_cyc();
        b_v = 1'b1; b_d = 8'h3C;
        smp();
        chk("hold_b_blocked_c2", rb[0], 1'b0);
        next_cyc();
        next_cyc();
        smp();
        chk("hold_b_blocked_c4", rb[0], 1'b0);
        next_cyc();
        smp();
        chk("hold_b_ready_c5", rb[0], 1'b1);
        next_cyc();
        b_v = 1'b0;
        smp();
        chk("hold_b_led_c6", led[0], 8'h3C);
        chk("hold_b_owner_c6", {6'b0, own[0]}, 8'h02);

        // Reset in the middle of HOLD, HOLD_CYCLES=16
        do_reset();
        a_v = 1'b1; a_d = 8'h77; b_v = 1'b0;
        smp();
        chk("h16_ready_a_c0", ra[2], 1'b1);
        next_cyc();
        a_v = 1'b0;
        next_cyc();
        next_cyc();
        rst = 1'b1; a_v = 1'b1; a_d = 8'hC3;
        for (int c = 0; c < 2; c++) begin
            smp();
            chk("h16_rst_led", led[2], 8'h00);
            chk("h16_rst_owner", {6'b0, own[2]}, 8'h00);
            chk("h16_rst_ready", {6'b0, ra[2], rb[2]}, 8'h00);
            next_cyc();
        end
        rst = 1'b0;
        smp();
        chk("h16_ready_a_after_rst", ra[2], 1'b1);
        next_cyc();
        a_v = 1'b0;
        smp();
        chk("h16_led_after_rst", led[2], 8'hC3);
        chk("h16_owner_after_rst", {6'b0, own[2]}, 8'h01);

        // Random traffic with occasional resets
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            next_cyc();
            rst = ($urandom_range(0, 199) == 0);
            a_v = ($urandom_range(0, 2) != 0);
            b_v = ($urandom_range(0, 2) != 0);
            a_d = 8'($urandom);
            b_d = 8'($urandom);
        end

`ifdef LED_SHARE_ARB_BLINK_EN
        // Rotation after idle timeout, and a write coinciding with a timeout
        do_reset();
        a_v = 1'b1; a_d = 8'h81; b_v = 1'b0;
        for (int c = 1; c <= 33; c++) begin
            next_cyc();
            a_v = (c == 24);
            a_d = (c == 24) ? 8'hF0 : 8'h00;
            smp();
            if (c == 8)  chk("blink_c8", led[0], 8'h81);
            if (c == 9)  chk("blink_c9", led[0], 8'h03);
            if (c == 16) chk("blink_c16", led[0], 8'h03);
            if (c == 17) chk("blink_c17", led[0], 8'h06);
            if (c == 24) chk("blink_ready_c24", ra[0], 1'b1);
            if (c == 25) chk("blink_write_c25", led[0], 8'hF0);
            if (c == 33) chk("blink_c33", led[0], 8'hE1);
            if (c == 33) chk("blink_owner_c33", {6'b0, own[0]}, 8'h01);
        end
`endif

        next_cyc();
        a_v = 1'b0; b_v = 1'b0;
        smp();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
